// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: oversamples the SPI pins in the clk domain, assembles
// MSB-first bytes with a one-cycle done strobe and shifts the controller's reply out on MISO.
module spi_slave_if #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    input  logic [7:0] spi_byte_out,
    output logic [7:0] spi_byte_in,
    output logic       spi_cycle_done,
    output logic       spi_active
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;

    logic [BYTE_W-1:0] rx_shift, rx_nxt;
    logic [BYTE_W-1:0] tx_shift, tx_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic              load_pending, load_nxt;
    logic [BYTE_W-1:0] byte_in_nxt;
    logic              done_nxt;
    logic              miso_nxt;
    logic              active_nxt;

    // Pin synchronizers plus one history flop for sclk and cs_n edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    // Next-state: deselect dominates, then frame start, then sclk sample/shift
    always_comb begin
        rx_nxt      = rx_shift;
        tx_nxt      = tx_shift;
        cnt_nxt     = bit_cnt;
        load_nxt    = load_pending;
        byte_in_nxt = spi_byte_in;
        done_nxt    = 1'b0;
        miso_nxt    = ~cs_s & tx_shift[BYTE_W-1];
        active_nxt  = ~cs_s;

        if (cs_s) begin
            cnt_nxt  = '0;
            load_nxt = 1'b0;
        end else if (cs_fall) begin
            tx_nxt  = spi_byte_out;
            cnt_nxt = '0;
            rx_nxt  = '0;
        end else if (sclk_rise) begin
            rx_nxt  = {rx_shift[BYTE_W-2:0], mosi_s};
            cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
                byte_in_nxt = {rx_shift[BYTE_W-2:0], mosi_s};
                done_nxt    = 1'b1;
                load_nxt    = 1'b1;
            end
        end else if (sclk_fall) begin
            if (load_pending) begin
                tx_nxt   = spi_byte_out;
                load_nxt = 1'b0;
            end else begin
                tx_nxt = {tx_shift[BYTE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_shift       <= '0;
            tx_shift       <= '0;
            bit_cnt        <= '0;
            load_pending   <= 1'b0;
            spi_byte_in    <= '0;
            spi_cycle_done <= 1'b0;
            spi_miso       <= 1'b0;
            spi_active     <= 1'b0;
        end else begin
            rx_shift       <= rx_nxt;
            tx_shift       <= tx_nxt;
            bit_cnt        <= cnt_nxt;
            load_pending   <= load_nxt;
            spi_byte_in    <= byte_in_nxt;
            spi_cycle_done <= done_nxt;
            spi_miso       <= miso_nxt;
            spi_active     <= active_nxt;
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: SPI master tasks at f_clk/8, strobe monitor and a
// simple response-controller model, with immediate assertions at each check point.
module tb_spi_slave_if;

    localparam int unsigned SYNC = 2;
    localparam int unsigned HALF = 4;
    localparam int unsigned MAXS = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic [7:0] spi_byte_out;
    logic [7:0] spi_byte_in;
    logic       spi_cycle_done;
    logic       spi_active;

    int checks = 0;
    int errors = 0;

    logic [7:0] byte_out_set = 8'h00;
    logic       model_en = 1'b0;

    int         cyc = 0;
    int         n_str = 0;
    int         dbl = 0;
    logic       prev_done = 1'b0;
    logic [7:0] strobe_byte [MAXS];
    int         strobe_cyc [MAXS];

    spi_slave_if #(.SYNC_STAGES(SYNC)) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .spi_cs_n       (spi_cs_n),
        .spi_miso       (spi_miso),
        .spi_byte_out   (spi_byte_out),
        .spi_byte_in    (spi_byte_in),
        .spi_cycle_done (spi_cycle_done),
        .spi_active     (spi_active)
    );

    always #5 clk = ~clk;

    // Controller model: fixed reply byte, or received byte + 1 on each strobe
    always @(negedge clk) begin
        if (!model_en)
            spi_byte_out <= byte_out_set;
        else if (spi_cycle_done)
            spi_byte_out <= spi_byte_in + 8'h01;
    end

    // Strobe monitor: records each strobe's byte and cycle, flags wide strobes
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_done <= spi_cycle_done;
        if (spi_cycle_done && prev_done)
            dbl <= dbl + 1;
        if (spi_cycle_done && n_str < int'(MAXS)) begin
            strobe_byte[n_str] <= spi_byte_in;
            strobe_cyc[n_str]  <= cyc;
            n_str              <= n_str + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master: drive MOSI on sclk fall, sample MISO just before sclk rise
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(HALF);
            rx[7-i] = spi_miso;
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(2);
        spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    initial begin
        logic [7:0] rx;
        int n0;
        int gap;

        rst      = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        wait_clk(3);
        check("rst_miso", 32'(spi_miso), 32'h0);
        check("rst_byte_in", 32'(spi_byte_in), 32'h00);
        check("rst_done", 32'(spi_cycle_done), 32'h0);
        check("rst_active", 32'(spi_active), 32'h0);
        rst = 1'b1;
        wait_clk(4);

        // Single byte: receive A5, master reads C3
        byte_out_set = 8'hC3;
        wait_clk(2);
        n0 = n_str;
        frame_start();
        check("active_sel", 32'(spi_active), 32'h1);
        xfer(8'hA5, 8, rx);
        check("single_miso", 32'(rx), 32'hC3);
        check("single_strobes", 32'(n_str - n0), 32'd1);
        check("single_byte_in", 32'(spi_byte_in), 32'hA5);
        check("single_strobe_byte", 32'(strobe_byte[n0]), 32'hA5);
        frame_end();
        check("active_desel", 32'(spi_active), 32'h0);

        // Deselected clocking: 16 sclk toggles ignored, MISO low
        n0 = n_str;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = 1'b1;
            wait_clk(HALF);
            check("desel_miso", 32'(spi_miso), 32'h0);
            spi_sclk = ~spi_sclk;
        end
        wait_clk(2 * HALF);
        check("desel_strobes", 32'(n_str - n0), 32'd0);

        // Aborted byte after 5 bits, then a full 3C frame
        n0 = n_str;
        frame_start();
        xfer(8'hFF, 5, rx);
        frame_end();
        check("abort_strobes", 32'(n_str - n0), 32'd0);
        check("abort_byte_in", 32'(spi_byte_in), 32'hA5);
        frame_start();
        xfer(8'h3C, 8, rx);
        frame_end();
        check("after_abort_strobes", 32'(n_str - n0), 32'd1);
        check("after_abort_byte_in", 32'(spi_byte_in), 32'h3C);

        // Reset mid-frame after 3 bits while MISO is driving ones
        byte_out_set = 8'hFF;
        wait_clk(2);
        frame_start();
        xfer(8'hF0, 3, rx);
        check("pre_rst_miso", 32'(spi_miso), 32'h1);
        rst = 1'b0;
        wait_clk(1);
        check("midrst_miso", 32'(spi_miso), 32'h0);
        check("midrst_byte_in", 32'(spi_byte_in), 32'h00);
        check("midrst_done", 32'(spi_cycle_done), 32'h0);
        check("midrst_active", 32'(spi_active), 32'h0);
        spi_cs_n = 1'b1;
        wait_clk(HALF);
        rst = 1'b1;
        wait_clk(HALF);
        n0 = n_str;
        frame_start();
        xfer(8'h5A, 8, rx);
        frame_end();
        check("post_rst_strobes", 32'(n_str - n0), 32'd1);
        check("post_rst_byte_in", 32'(spi_byte_in), 32'h5A);

        // Multi-byte frame with controller replying received+1
        byte_out_set = 8'h77;
        wait_clk(2);
        model_en = 1'b1;
        wait_clk(2);
        n0 = n_str;
        frame_start();
        xfer(8'h05, 8, rx);
        check("multi_rx0", 32'(rx), 32'h77);
        xfer(8'h01, 8, rx);
        check("multi_rx1", 32'(rx), 32'h06);
        xfer(8'h2C, 8, rx);
        check("multi_rx2", 32'(rx), 32'h02);
        frame_end();
        model_en = 1'b0;
        check("multi_strobes", 32'(n_str - n0), 32'd3);
        check("multi_byte0", 32'(strobe_byte[n0]), 32'h05);
        check("multi_byte1", 32'(strobe_byte[n0+1]), 32'h01);
        check("multi_byte2", 32'(strobe_byte[n0+2]), 32'h2C);

        // Back-to-back bytes: strobes 64 clk apart, never two cycles wide
        byte_out_set = 8'h96;
        wait_clk(2);
        n0 = n_str;
        frame_start();
        xfer(8'h11, 8, rx);
        check("b2b_rx0", 32'(rx), 32'h96);
        xfer(8'h22, 8, rx);
        xfer(8'h33, 8, rx);
        xfer(8'h44, 8, rx);
        frame_end();
        check("b2b_strobes", 32'(n_str - n0), 32'd4);
        check("b2b_last_byte", 32'(spi_byte_in), 32'h44);
        for (int k = 1; k < 4; k++) begin
            gap = strobe_cyc[n0+k] - strobe_cyc[n0+k-1];
            check("b2b_gap", 32'(gap >= 62 && gap <= 66), 32'h1);
        end
        check("strobe_width", 32'(dbl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
